// File: rtl/mips_pkg.sv
// Shared constants for the MULT/DIV unit: default datapath width, op codes, FSM states.
package mips_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide.
// Divide path only exists when MULDIV_DIV_EN is defined.
module muldiv_step
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mq,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] mq_next
);

  logic [WIDTH:0] sum;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
`else
  logic unused_div_mode;
  assign unused_div_mode = div_mode;
`endif

  always_comb begin
    // {acc,mq} holds the partial product; low bit of mq selects the add
    sum      = {1'b0, acc} + (mq[0] ? {1'b0, operand} : '0);
    acc_next = sum[WIDTH:1];
    mq_next  = {sum[0], mq[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    // acc is the partial remainder, mq shifts dividend bits out and quotient bits in
    shifted = {acc, mq[WIDTH-1]};
    diff    = shifted - {1'b0, operand};
    if (div_mode) begin
      if (!diff[WIDTH]) begin
        acc_next = diff[WIDTH-1:0];
        mq_next  = {mq[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = shifted[WIDTH-1:0];
        mq_next  = {mq[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, 1 bit per cycle.
// Divider enabled by defining MULDIV_DIV_EN; otherwise DIV/DIVU complete as no-ops.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] mt_data,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IW = $clog2(WIDTH);
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  state_e           state;
  logic [IW-1:0]    iter;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] opnd;
  logic             is_div;
  logic             neg_res;
  logic             neg_rem;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] mq_next;

  logic             signed_op;
  logic             div_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    signed_op = (op_e'(op) == OP_MULT) || (op_e'(op) == OP_DIV);
    div_op    = (op_e'(op) == OP_DIV)  || (op_e'(op) == OP_DIVU);
    a_neg     = signed_op && operand_a[WIDTH-1];
    b_neg     = signed_op && operand_b[WIDTH-1];
    a_mag     = a_neg ? -operand_a : operand_a;
    b_mag     = b_neg ? -operand_b : operand_b;
  end

  assign busy = (state != S_IDLE);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (state == S_DIV),
    .acc      (acc),
    .mq       (mq),
    .operand  (opnd),
    .acc_next (acc_next),
    .mq_next  (mq_next)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      iter    <= '0;
      acc     <= '0;
      mq      <= '0;
      opnd    <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi_out  <= '0;
      lo_out  <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mthi_we) hi_out <= mt_data;
          if (mtlo_we) lo_out <= mt_data;
          if (start) begin
            iter    <= IW'(WIDTH - 1);
            acc     <= '0;
            mq      <= a_mag;
            opnd    <= b_mag;
            is_div  <= div_op;
            // divide by zero keeps the all-ones quotient unnegated
            neg_res <= (a_neg ^ b_neg) && (!div_op || (operand_b != '0));
            neg_rem <= a_neg;
            state   <= div_op ? S_DIV : S_MUL;
          end
        end
        S_MUL, S_DIV: begin
          acc  <= acc_next;
          mq   <= mq_next;
          iter <= iter - IW'(1);
          if ((iter == '0) || (state == S_DIV && !DIV_EN)) state <= S_FIX;
        end
        S_FIX: begin
          if (!is_div) begin
            {hi_out, lo_out} <= neg_res ? -{acc, mq} : {acc, mq};
          end else if (DIV_EN) begin
            lo_out <= neg_res ? -mq : mq;
            hi_out <= neg_rem ? -acc : acc;
          end
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
